// File: rtl/instr_queue_pkg.sv
// Shared types and helpers for the fetch-side instruction queue.
// Optional same-cycle bypass is enabled by defining INSTR_QUEUE_BYPASS_EN.
package instr_queue_pkg;

    localparam int IQ_DEPTH_DEFAULT = 8;
    localparam int IQ_XLEN          = 32;

    typedef struct packed {
        logic [IQ_XLEN-1:0] pc;
        logic [IQ_XLEN-1:0] instr;
        logic               pred_taken;
    } iq_entry_t;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int iq_ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic iq_entry_t make_entry(
        input logic [IQ_XLEN-1:0] pc,
        input logic [IQ_XLEN-1:0] instr,
        input logic               pred_taken
    );
        iq_entry_t e;
        e.pc         = pc;
        e.instr      = instr;
        e.pred_taken = pred_taken;
        return e;
    endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Fetch/decode side signals of the instruction queue. The master side is the
// fetch stage plus decode environment; the slave side is the queue itself.
interface instr_queue_if;
    import instr_queue_pkg::*;

    logic               mispredict;
    logic               imem_resp;
    logic               instr_v;
    logic [IQ_XLEN-1:0] fetch_pc;
    logic [IQ_XLEN-1:0] imem_rdata;
    logic               pred_taken;
    logic               stall;
    logic               dq_valid;
    logic               dq_ready;
    logic [IQ_XLEN-1:0] dq_pc;
    logic [IQ_XLEN-1:0] dq_instr;
    logic               dq_pred_taken;

    modport master (
        output mispredict, imem_resp, instr_v, fetch_pc, imem_rdata, pred_taken, dq_ready,
        input  stall, dq_valid, dq_pc, dq_instr, dq_pred_taken
    );

    modport slave (
        input  mispredict, imem_resp, instr_v, fetch_pc, imem_rdata, pred_taken, dq_ready,
        output stall, dq_valid, dq_pc, dq_instr, dq_pred_taken
    );

endinterface

// File: rtl/instr_queue_iq_ram.sv
// Entry storage for the instruction queue: one write port, one asynchronous
// read port, no reset (contents are qualified by the pointers in the top).
module iq_ram
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT,
    parameter int AW    = iq_ptr_width(DEPTH)
) (
    input  logic      clk,
    input  logic      we,
    input  logic [AW-1:0] waddr,
    input  iq_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output iq_entry_t rdata
);

    iq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Circular instruction buffer between fetch and decode with mispredict flush.
// Define INSTR_QUEUE_BYPASS_EN to let an entry reach decode in the cycle it
// arrives when the queue is empty and decode is ready.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
    input logic         clk,
    input logic         rst,
    instr_queue_if.slave iq
);

    localparam int AW = iq_ptr_width(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;

    logic      full;
    logic      empty;
    logic      enq;
    logic      deq;
    logic      bypass;
    logic      ram_we;
    logic      ram_pop;
    iq_entry_t in_entry;
    iq_entry_t head_entry;
    iq_entry_t out_entry;

    // Full/empty come only from registered count, so a same-cycle dequeue
    // never lets a response in while full.
    assign full     = (count_reg == FULL_COUNT);
    assign empty    = (count_reg == '0);
    assign iq.stall = full;

    assign in_entry = make_entry(iq.fetch_pc, iq.imem_rdata, iq.pred_taken);
    assign enq      = iq.imem_resp & iq.instr_v & ~iq.mispredict & ~full;

`ifdef INSTR_QUEUE_BYPASS_EN
    assign bypass    = empty & enq & iq.dq_ready;
    assign out_entry = empty ? in_entry : head_entry;
`else
    assign bypass    = 1'b0;
    assign out_entry = head_entry;
`endif

    assign iq.dq_valid      = (~empty | bypass) & ~iq.mispredict;
    assign iq.dq_pc         = out_entry.pc;
    assign iq.dq_instr      = out_entry.instr;
    assign iq.dq_pred_taken = out_entry.pred_taken;

    assign deq = iq.dq_valid & iq.dq_ready;

    // A bypassed entry goes straight to decode and never touches storage.
    assign ram_we  = enq & ~bypass;
    assign ram_pop = deq & ~bypass;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (iq.mispredict) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (ram_we) begin
                tail_next = tail_reg + AW'(1);
            end
            if (ram_pop) begin
                head_next = head_reg + AW'(1);
            end
            case ({ram_we, ram_pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    iq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (tail_reg),
        .wdata (in_entry),
        .raddr (head_reg),
        .rdata (head_entry)
    );

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a queue-based reference model checked every
// cycle, plus literal expectations from the test plan. Bypass-aware via INSTR_QUEUE_BYPASS_EN.
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   check_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    iq_entry_t model_q[$];

    instr_queue_if iq ();

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .iq  (iq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_valid_f();
        if (iq.mispredict) return 1'b0;
        if (model_q.size() > 0) return 1'b1;
`ifdef INSTR_QUEUE_BYPASS_EN
        return iq.imem_resp && iq.instr_v && iq.dq_ready;
`else
        return 1'b0;
`endif
    endfunction

    function automatic iq_entry_t exp_head_f();
        if (model_q.size() > 0) return model_q[0];
        return make_entry(iq.fetch_pc, iq.imem_rdata, iq.pred_taken);
    endfunction

    // Reference model: a plain bounded FIFO updated with the inputs of the cycle.
    always @(posedge clk) begin
        bit v;
        bit enq_ok;
        bit byp;
        if (rst || iq.mispredict) begin
            model_q.delete();
        end else begin
            v      = exp_valid_f();
            enq_ok = iq.imem_resp && iq.instr_v && (model_q.size() < DEPTH);
            byp    = v && iq.dq_ready && (model_q.size() == 0);
            if (!byp) begin
                if (v && iq.dq_ready) void'(model_q.pop_front());
                if (enq_ok) model_q.push_back(make_entry(iq.fetch_pc, iq.imem_rdata, iq.pred_taken));
            end
        end
    end

    always @(negedge clk) begin
        iq_entry_t h;
        bit v;
        if (check_en) begin
            v = exp_valid_f();
            h = exp_head_f();
            chk("stall", iq.stall, (model_q.size() == DEPTH));
            chk("dq_valid", iq.dq_valid, v);
            chk("count", dut.count_reg, model_q.size());
            if (v) begin
                chk("dq_pc", iq.dq_pc, h.pc);
                chk("dq_instr", iq.dq_instr, h.instr);
                chk("dq_pred_taken", iq.dq_pred_taken, h.pred_taken);
            end
            $display("cyc t=%0t resp=%b v=%b mis=%b rdy=%b | valid=%b pc=%h stall=%b cnt=%0d",
                     $time, iq.imem_resp, iq.instr_v, iq.mispredict, iq.dq_ready,
                     iq.dq_valid, iq.dq_pc, iq.stall, dut.count_reg);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic resp, input logic v, input logic [31:0] pc,
                         input logic [31:0] instr, input logic pred, input logic rdy,
                         input logic mis);
        iq.imem_resp  = resp;
        iq.instr_v    = v;
        iq.fetch_pc   = pc;
        iq.imem_rdata = instr;
        iq.pred_taken = pred;
        iq.dq_ready   = rdy;
        iq.mispredict = mis;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check_en = 1'b1;
        #1;
        chk("reset_stall", iq.stall, 1'b0);
        chk("reset_valid", iq.dq_valid, 1'b0);

        // Single enqueue, visible the next cycle
        drive(1'b1, 1'b1, 32'h6000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        tick(); idle(); #1;
        chk("first_valid", iq.dq_valid, 1'b1);
        chk("first_pc", iq.dq_pc, 32'h6000_0000);
        chk("first_instr", iq.dq_instr, 32'h0000_0013);
        iq.dq_ready = 1'b1;
        tick(); idle();

        // Fill to full, drop the ninth, drain in order
        for (int i = 0; i < 8; i++) begin
            pc = 32'h6000_0000 + 32'(4 * i);
            drive(1'b1, 1'b1, pc, 32'h0000_0013 | 32'(i << 7), i[0], 1'b0, 1'b0);
            tick();
        end
        idle(); #1;
        chk("full_stall", iq.stall, 1'b1);
        drive(1'b1, 1'b1, 32'h6000_0020, 32'h0000_0493, 1'b0, 1'b0, 1'b0);
        tick(); idle(); #1;
        chk("drop_stall", iq.stall, 1'b1);
        chk("drop_head", iq.dq_pc, 32'h6000_0000);
        for (int i = 0; i < 8; i++) begin
            iq.dq_ready = 1'b1;
            #1;
            chk("drain_pc", iq.dq_pc, 32'h6000_0000 + 32'(4 * i));
            tick();
            if (i == 0) chk("stall_release", iq.stall, 1'b0);
        end
        idle(); #1;
        chk("drained_valid", iq.dq_valid, 1'b0);

        // Steady simultaneous enq/deq at count 3 across the pointer wrap
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'h6000_0200 + 32'(4 * k), 32'h0010_0093 + 32'(k), 1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int k = 3; k < 13; k++) begin
            drive(1'b1, 1'b1, 32'h6000_0200 + 32'(4 * k), 32'h0010_0093 + 32'(k), k[0], 1'b1, 1'b0);
            tick();
        end
        idle(); #1;
        chk("steady_count", dut.count_reg, 32'd3);
        chk("steady_head", iq.dq_pc, 32'h6000_0228);
        iq.dq_ready = 1'b1;
        repeat (3) tick();
        idle();

        // Mispredict with five entries and a live response in the same cycle
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 32'h6000_0300 + 32'(4 * k), 32'h0000_0113, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h6000_0314, 32'h0000_0113, 1'b0, 1'b1, 1'b1);
        #1;
        chk("flush_valid_same", iq.dq_valid, 1'b0);
        tick(); idle(); #1;
        chk("flush_valid_next", iq.dq_valid, 1'b0);
        chk("flush_count", dut.count_reg, 32'd0);
        drive(1'b1, 1'b1, 32'h6000_0100, 32'h0000_0193, 1'b1, 1'b0, 1'b0);
        tick(); idle(); #1;
        chk("post_flush_pc", iq.dq_pc, 32'h6000_0100);
        chk("post_flush_pred", iq.dq_pred_taken, 1'b1);

        // Squashed response is ignored
        drive(1'b1, 1'b0, 32'h6000_0500, 32'h0000_0213, 1'b0, 1'b0, 1'b0);
        tick(); idle(); #1;
        chk("squash_count", dut.count_reg, 32'd1);
        chk("squash_head", iq.dq_pc, 32'h6000_0100);
        iq.dq_ready = 1'b1;
        tick(); idle();

        // Empty queue, enqueue with decode ready
        drive(1'b1, 1'b1, 32'h6000_0040, 32'h0000_0293, 1'b0, 1'b1, 1'b0);
        #1;
`ifdef INSTR_QUEUE_BYPASS_EN
        chk("bypass_valid", iq.dq_valid, 1'b1);
        chk("bypass_pc", iq.dq_pc, 32'h6000_0040);
        tick(); idle(); #1;
        chk("bypass_count", dut.count_reg, 32'd0);
        chk("bypass_after", iq.dq_valid, 1'b0);
`else
        chk("nobypass_valid", iq.dq_valid, 1'b0);
        tick(); idle(); #1;
        chk("nobypass_next", iq.dq_valid, 1'b1);
        chk("nobypass_pc", iq.dq_pc, 32'h6000_0040);
        iq.dq_ready = 1'b1;
        tick(); idle();
`endif

        // Mixed directed pattern, then reset mid-operation
        for (int i = 0; i < 40; i++) begin
            drive((i % 3) != 0, (i % 7) != 5, 32'h6000_1000 + 32'(4 * i),
                  32'h0000_0313 + 32'(i), i[1], (i % 4) < 2, i == 29);
            tick();
        end
        drive(1'b1, 1'b1, 32'h6000_2000, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h6000_2004, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_valid", iq.dq_valid, 1'b0);
        chk("midrst_stall", iq.stall, 1'b0);
        chk("midrst_count", dut.count_reg, 32'd0);
        tick();

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
# instr_queue

Fetch-side instruction buffer sitting directly downstream of the PC update stage and imem, and upstream of decode. It captures each valid imem response together with its PC and branch-prediction bit. It holds the entries in a circular FIFO and presents them in order to decode through a valid/ready handshake. It back-pressures the PC update stage via `stall` and discards all contents on a mispredict flush.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥ 2
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `mispredict`  in  1  flush request from backend
- `imem_resp`  in  1  imem data valid this cycle
- `instr_v`  in  1  response belongs to a live (non-squashed) fetch; from PC update stage
- `fetch_pc`  in  32  PC of the instruction in `imem_rdata`
- `imem_rdata`  in  32  instruction word
- `pred_taken`  in  1  branch predictor guess for `fetch_pc`
- `stall`  out  1  queue full; holds PC update stage
- `dq_valid`  out  1  head entry valid
- `dq_ready`  in  1  decode accepts head
- `dq_pc`  out  32  head PC
- `dq_instr`  out  32  head instruction
- `dq_pred_taken`  out  1  head prediction bit

## Operation
- State:
  - `head`/`tail` pointers, log2(DEPTH) bits, wrap naturally.
  - `count`, log2(DEPTH)+1 bits, range 0..DEPTH.
- Enqueue:
  - `enq = imem_resp & instr_v & ~mispredict & ~full`.
  - Writes {fetch_pc, imem_rdata, pred_taken} at `tail`; `tail++`.
- Dequeue:
  - `deq = dq_valid & dq_ready`; `head++`.
- Count: `+1` on enq only, `-1` on deq only, unchanged when both or neither.
- Full: `full = (count == DEPTH)`; `stall = full`.
  - A response arriving while full is dropped, not enqueued. The PC update stage has not advanced its PC, so it refetches.
  - A same-cycle deq does not unblock enq; `stall` is a pure function of registered `count`.
- Empty: `dq_valid = (count != 0) & ~mispredict`. `dq_*` data is don't-care when `dq_valid` = 0.
- Flush (`mispredict` = 1):
  - Next cycle `head = tail = 0`, `count = 0`.
  - Same-cycle enq is suppressed.
  - `dq_valid` is forced 0 that cycle, so no deq occurs.
  - Flush has priority over everything except `rst`.
- Reset: `head = tail = count = 0`.
  - `stall` = 0 and `dq_valid` = 0 from the cycle after `rst` sampled high.
  - Storage contents are not reset.
  - Reset mid-operation discards all entries, same as flush.

## Timing
- Enqueue-to-`dq_valid` latency is 1 cycle without bypass: data written at edge N is visible on `dq_*` in cycle N+1.
- `stall` is registered-derived and asserts in the cycle after the enq that fills the last slot.
- Decode may hold `dq_ready` low indefinitely. Head data is stable while `dq_valid` & ~`dq_ready`.
- Throughput: 1 enq + 1 deq per cycle sustained when not full.

## Configuration
- `INSTR_QUEUE_BYPASS_EN` defined: when `count` = 0, enq = 1 and `dq_ready` = 1 in the same cycle:
  - `dq_valid` = 1 and `dq_*` = incoming fields combinationally.
  - The entry is consumed without being written; pointers and `count` are unchanged.
  - If `dq_ready` = 0, the entry is written normally.
  - Mispredict still forces `dq_valid` = 0.
- Undefined: no combinational path from imem inputs to `dq_*`; latency is 1 cycle as above.

## Structure
- `rv32i_types` gains `iq_entry_t` (packed struct: `pc[31:0]`, `instr[31:0]`, `pred_taken`).
- Storage is one sub-module `iq_ram`:
  - DEPTH × `iq_entry_t`, 1 write port, 1 asynchronous read port, no reset.
  - Pointer, count, flush and bypass control live in `instr_queue`.

## Test plan
- Reset then idle → `stall` = 0, `dq_valid` = 0. Enqueue PC 0x60000000 / instr 0x00000013 → next cycle `dq_valid` = 1, `dq_pc` = 0x60000000, `dq_instr` = 0x00000013.
- Fill with 8 responses, `dq_ready` = 0 → `stall` = 1 after 8th. 9th response (0x60000020) dropped. Drain → PCs 0x60000000..0x6000001C in order, `stall` drops the cycle after first deq.
- Simultaneous enq/deq at `count` = 3 for 10 cycles, crossing pointer wrap → `count` stays 3, order preserved.
- With 5 entries, `mispredict` = 1 together with a valid response → next cycle `dq_valid` = 0, `count` = 0. Following enq of 0x60000100 appears as head.
- `instr_v` = 0 with `imem_resp` = 1 → nothing enqueued, `count` unchanged.
- Bypass build: empty queue, enq 0x60000040 with `dq_ready` = 1 → `dq_valid` = 1 same cycle, `count` stays 0. Non-bypass build: `dq_valid` appears next cycle.
